// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: bundle between the core/execute stage, the shared ALU and
// the iterative multiplier sequencer.
//   master : core side; drives start/op_a/op_b and the ALU result back in.
//   slave  : the sequencer; drives busy/done/product and the ALU operand/control mux.
// Signals:
//   start, op_a, op_b            multiply request and operands
//   busy, done, product          status and result
//   alu_own, alu_a, alu_b,       ALU ownership and operands/control while running
//   alu_cntl
//   alu_result                   combinational ALU output for alu_a/alu_b
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntl;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, product, alu_own, alu_a, alu_b, alu_cntl
  );

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, product, alu_own, alu_a, alu_b, alu_cntl
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add multiplier that borrows the shared ALU for
// its additions instead of owning an adder. Produces the low WIDTH bits of
// op_a*op_b (sign-agnostic, RV32M MUL semantics). One multiplier bit per cycle.
// Ports:
//   clk     system clock, all state on the rising edge
//   rst     synchronous, active-high reset (priority over everything, aborts a run)
//   bus_io  slave side of alu_mul_sequencer_if (start/op_a/op_b in; busy/done/product
//           out; alu_own/alu_a/alu_b/alu_cntl out; alu_result in)
// Build option:
//   EARLY_TERM_EN  when defined, a run finishes as soon as the remaining multiplier
//                  bits are all zero, instead of always taking WIDTH cycles.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [2:0]  ALU_ADD = 3'b000
) (
  input logic               clk,
  input logic               rst,
  alu_mul_sequencer_if.slave bus_io
);
  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;
  logic             load;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    acc_next  = acc_q;
    load      = 1'b0;

    unique case (state_q)
      StIdle: load = bus_io.start;
      StRun: begin
        // Zero-multiplier check wins over the bit counter.
        if (EarlyTerm && (mplier_q == '0)) begin
          product_d = acc_q;
          state_d   = StDone;
        end else begin
          // The ALU is adding acc + mcand this cycle; keep it only for a set bit.
          acc_next = mplier_q[0] ? bus_io.alu_result : acc_q;
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            product_d = acc_next;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        load    = bus_io.start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accepted start (IDLE or DONE): product is left alone until the new result.
    if (load) begin
      acc_d    = '0;
      mcand_d  = bus_io.op_a;
      mplier_d = bus_io.op_b;
      cnt_d    = '0;
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  // Status comes straight from the state register: no start->busy path.
  assign bus_io.busy     = (state_q == StRun);
  assign bus_io.alu_own  = (state_q == StRun);
  assign bus_io.done     = (state_q == StDone);
  assign bus_io.product  = product_q;
  assign bus_io.alu_a    = acc_q;
  assign bus_io.alu_b    = mcand_q;
  assign bus_io.alu_cntl = ALU_ADD;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a transaction-level model (product = a*b, done offset
// from op_b) checked against the DUT every cycle, directed cases with literal
// expectations, then a long randomized run with random starts and resets.
module tb_alu_mul_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer #(
    .WIDTH   (W),
    .ALU_ADD (3'b000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Shared ALU stand-in: anything other than ADD gives a visibly wrong result.
  assign bus.alu_result = (bus.alu_cntl == 3'b000) ? bus.alu_a + bus.alu_b
                                                   : bus.alu_a ^ bus.alu_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Intervals after the accepting edge until done: done is high D intervals later.
  function automatic int done_offset(input logic [31:0] b);
`ifdef EARLY_TERM_EN
    int msb;
    if (b == 0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return (2 + msb < int'(W)) ? 2 + msb : int'(W);
`else
    return int'(W);
`endif
  endfunction

  // Model state: one outstanding transaction accepted at edge m_n.
  bit          m_init  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_n     = 0;
  int          m_d     = 0;
  logic [31:0] m_prod  = '0;
  logic [31:0] m_new   = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_prod  = '0;
    end else if (m_init) begin
      if (m_valid && cyc == m_n + m_d) m_prod = m_new;
      if (bus.start && !(m_valid && (cyc - 1) >= m_n && (cyc - 1) < m_n + m_d)) begin
        m_n     = cyc;
        m_d     = done_offset(bus.op_b);
        m_new   = bus.op_a * bus.op_b;
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic exp_busy, exp_done;
      exp_busy = m_valid && cyc >= m_n && cyc < m_n + m_d;
      exp_done = m_valid && cyc == m_n + m_d;
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("alu_own", 32'(bus.alu_own), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("product", bus.product, m_prod);
      chk("alu_cntl", 32'(bus.alu_cntl), 32'd0);
    end
  end

  task automatic go(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
  endtask

  // Called at the negedge where start was driven; returns negedges until done.
  task automatic wait_done(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.done) break;
      if (bus.busy) nbusy++;
      if (n > 60) begin
        chk("done_timeout", 32'(bus.done), 32'd1);
        break;
      end
    end
  endtask

  initial begin
    int n, nb, ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", bus.product, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);

    // 6*7, then back-to-back 3*5 issued in the done cycle.
    @(negedge clk);
    go(32'd6, 32'd7);
    wait_done(n, nb);
    chk("t1_product", bus.product, 32'd42);
`ifndef EARLY_TERM_EN
    chk("t1_latency", 32'(n), 32'd33);
    chk("t1_busy_cycles", 32'(nb), 32'd32);
`endif
    go(32'd3, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_busy_next", 32'(bus.busy), 32'd1);
    chk("t5_held", bus.product, 32'd42);
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t5_product", bus.product, 32'd15);
`ifndef EARLY_TERM_EN
    chk("t5_latency", 32'(n), 32'd33);
`endif

    // Wrap-around cases.
    @(negedge clk);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, nb);
    chk("t2_wrap_ones", bus.product, 32'h0000_0001);
    @(negedge clk);
    go(32'h8000_0000, 32'd2);
    wait_done(n, nb);
    chk("t2_wrap_zero", bus.product, 32'h0000_0000);

    // start held high with new operands throughout the run is ignored.
    @(negedge clk);
    go(32'd12345, 32'h8000_0003);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 20) go($urandom, $urandom);
      else bus.start = 1'b0;
      if (bus.done) ndone++;
    end
    chk("t3_single_done", 32'(ndone), 32'd1);
    chk("t3_product", bus.product, 32'h8000_90AB);

    // Reset in the 10th run cycle aborts with no done afterwards.
    go(32'h1234, 32'hFFFF_0F0F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_alu_own", 32'(bus.alu_own), 32'd0);
    chk("t4_product", bus.product, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t4_no_done", 32'(ndone), 32'd0);

`ifdef EARLY_TERM_EN
    go(32'd77, 32'd0);
    wait_done(n, nb);
    chk("t6_zero_latency", 32'(n), 32'd2);
    chk("t6_zero_product", bus.product, 32'd0);
    @(negedge clk);
    go(32'd5, 32'd1);
    wait_done(n, nb);
    chk("t6_one_latency", 32'(n), 32'd3);
    chk("t6_one_product", bus.product, 32'd5);
    @(negedge clk);
    go(32'd9, 32'd4);
    wait_done(n, nb);
    chk("t6_product", bus.product, 32'd36);
`endif

    // Random traffic: frequent starts (many ignored, some back-to-back), rare resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op_a  = $urandom;
      bus.op_b  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) bus.op_b = '0;
      rst = ($urandom_range(0, 299) == 0);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
